mem_arbiter: RTL

//  Sole owner of the byte-wide RAM/IO port. Arbitrates ICache line refills vs LSB load/store requests,

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: RAM/IO port plus ICache refill and LSB request channels of the memory arbiter
interface mem_arbiter_if #(
  parameter int LINE_BYTES = 16
);
  logic rdy;
  logic [31:0] ram_a;
  logic [7:0] ram_dout;
  logic ram_wr;
  logic [7:0] ram_din;
  logic io_buffer_full;
  logic flush;
  logic ic_req;
  logic [31:0] ic_addr;
  logic ic_valid;
  logic [8*LINE_BYTES-1:0] ic_line;
  logic lsb_req;
  logic lsb_we;
  logic [1:0] lsb_size;
  logic lsb_signed;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic lsb_done;
  logic [31:0] lsb_rdata;
  modport master (
    input rdy, ram_din, io_buffer_full, flush, ic_req, ic_addr,
          lsb_req, lsb_we, lsb_size, lsb_signed, lsb_addr, lsb_wdata,
    output ram_a, ram_dout, ram_wr, ic_valid, ic_line, lsb_done, lsb_rdata
  );
  modport slave (
    output rdy, ram_din, io_buffer_full, flush, ic_req, ic_addr,
           lsb_req, lsb_we, lsb_size, lsb_signed, lsb_addr, lsb_wdata,
    input ram_a, ram_dout, ram_wr, ic_valid, ic_line, lsb_done, lsb_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates ICache refills vs LSB accesses onto the byte-serial RAM/IO port
module mem_arbiter #(
  parameter int LINE_BYTES = 16,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.master bus
);
  localparam int W = $clog2(LINE_BYTES) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;
  state_t state;
  logic [31:0] base, ram_a, wdat, rdata, ext;
  logic [W-1:0] n, cnt, pidx;
  logic [SW-1:0] starve;
  logic [8*LINE_BYTES-1:0] buf_q, nbuf, line;
  logic [7:0] dout;
  logic [1:0] sz;
  logic sgn, a_act, pend, wr_q, ic_v, done;
  logic stall, issue, last, ic_pick, lsb_pick;
  assign stall = a_act & bus.io_buffer_full & (ram_a[17:16] == 2'b11);
  assign issue = a_act & ~stall;
  assign last = cnt == n - 1'b1;
  assign ic_pick = bus.ic_req & ~bus.flush & (~bus.lsb_req | (starve == SW'(STARVE_LIMIT)));
  assign lsb_pick = bus.lsb_req & ~ic_pick;
  assign ext = sz == 2'b10 ? nbuf[31:0] :
               sz == 2'b01 ? {{16{sgn & nbuf[15]}}, nbuf[15:0]} :
               {{24{sgn & nbuf[7]}}, nbuf[7:0]};
  assign bus.ram_a = ram_a;
  assign bus.ram_dout = dout;
  assign bus.ram_wr = wr_q & bus.rdy & ~stall;
  assign bus.ic_valid = ic_v;
  assign bus.ic_line = line;
  assign bus.lsb_done = done;
  assign bus.lsb_rdata = rdata;
  always_comb begin
    nbuf = buf_q;
    if (pend) nbuf[{pidx, 3'b000} +: 8] = bus.ram_din;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      base <= '0;
      ram_a <= '0;
      wdat <= '0;
      rdata <= '0;
      n <= '0;
      cnt <= '0;
      pidx <= '0;
      starve <= '0;
      buf_q <= '0;
      line <= '0;
      dout <= '0;
      sz <= '0;
      sgn <= 1'b0;
      a_act <= 1'b0;
      pend <= 1'b0;
      wr_q <= 1'b0;
      ic_v <= 1'b0;
      done <= 1'b0;
    end else if (bus.rdy) begin
      ic_v <= 1'b0;
      done <= 1'b0;
      buf_q <= nbuf;
      if (!bus.ic_req) starve <= '0;
      if (state == IDLE) begin
        if (!ic_v && !done && (ic_pick || lsb_pick)) begin
          state <= ic_pick ? IFETCH : bus.lsb_we ? STORE : LOAD;
          base <= ic_pick ? bus.ic_addr : bus.lsb_addr;
          ram_a <= ic_pick ? bus.ic_addr : bus.lsb_addr;
          n <= ic_pick ? W'(LINE_BYTES) : bus.lsb_size == 2'b10 ? W'(4) : bus.lsb_size == 2'b01 ? W'(2) : W'(1);
          cnt <= '0;
          a_act <= 1'b1;
          sz <= bus.lsb_size;
          sgn <= bus.lsb_signed;
          wdat <= bus.lsb_wdata;
          wr_q <= lsb_pick & bus.lsb_we;
          dout <= (lsb_pick & bus.lsb_we) ? bus.lsb_wdata[7:0] : 8'h00;
          starve <= (ic_pick || !bus.ic_req) ? '0 : starve == SW'(STARVE_LIMIT) ? starve : starve + 1'b1;
        end
      end else if (state == IFETCH && bus.flush) begin
        state <= IDLE;
        ram_a <= '0;
        cnt <= '0;
        a_act <= 1'b0;
        pend <= 1'b0;
      end else begin
        pend <= issue & (state != STORE);
        if (issue) begin
          pidx <= cnt;
          cnt <= cnt + 1'b1;
          a_act <= !last;
          ram_a <= last ? '0 : base + 32'(cnt) + 32'd1;
          wr_q <= !last & (state == STORE);
          dout <= (last || state != STORE) ? 8'h00 : wdat[{cnt[1:0] + 2'd1, 3'b000} +: 8];
        end
        if (state == STORE && issue && last) begin
          state <= IDLE;
          done <= 1'b1;
          rdata <= '0;
        end
        if (state != STORE && pend && pidx == n - 1'b1) begin
          state <= IDLE;
          ic_v <= state == IFETCH;
          done <= state != IFETCH;
          line <= state == IFETCH ? nbuf : line;
          rdata <= state == IFETCH ? rdata : ext;
        end
      end
    end
endmodule
